nibble_serial_add_ctrl: RTL

NIBBLE_SERIAL_ADD_CTRL -- requirements
Module: nibble_serial_add_ctrl

---
 rtl/nibble_serial_add_ctrl.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl
// Bit-serial-by-nibble adder: one 4-bit ripple slice is reused across
// NIBBLES cycles to add two W = 4*NIBBLES bit operands.
// Handshake in (in_valid/in_ready), result out (out_valid/out_ready).
// Optional build macro NIBBLE_SERIAL_SUB_EN adds an 'op' port; op=1 gives a - b.
module nibble_serial_add_ctrl #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic                   cin,
`ifdef NIBBLE_SERIAL_SUB_EN
    input  logic                   op,
`endif
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   sum,
    output logic                   cout,
    output logic                   busy
);

    localparam int unsigned W  = 4 * NIBBLES;
    localparam int unsigned IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t          r_state;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic            r_carry;
    logic [IW-1:0]   r_idx;
    logic [W-1:0]    r_sum;
    logic            r_cout;
    logic            r_out_valid;
    logic            r_in_ready;
    logic            r_busy;

    logic [3:0]      w_a_nib;
    logic [3:0]      w_b_nib;
    logic [4:0]      w_slice;
    logic [W-1:0]    w_b_load;
    logic            w_carry_load;

    // Select the current nibble of each operand register.
    always_comb begin
        w_a_nib = '0;
        w_b_nib = '0;
        for (int unsigned n = 0; n < NIBBLES; n++) begin
            if (r_idx == IW'(n)) begin
                w_a_nib = r_a[4*n +: 4];
                w_b_nib = r_b[4*n +: 4];
            end
        end
    end

    // The single shared 4-bit ripple slice.
    always_comb begin
        w_slice = {1'b0, w_a_nib} + {1'b0, w_b_nib} + {4'b0000, r_carry};
    end

    // Operand B and carry as loaded at the handshake (subtract inverts B, carry=1).
    always_comb begin
`ifdef NIBBLE_SERIAL_SUB_EN
        w_b_load     = op ? ~b : b;
        w_carry_load = op ? 1'b1 : cin;
`else
        w_b_load     = b;
        w_carry_load = cin;
`endif
    end

    // Control FSM with registered handshake/status outputs and the result word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_carry     <= 1'b0;
            r_idx       <= '0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a        <= a;
                        r_b        <= w_b_load;
                        r_carry    <= w_carry_load;
                        r_idx      <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    for (int unsigned n = 0; n < NIBBLES; n++) begin
                        if (r_idx == IW'(n)) begin
                            r_sum[4*n +: 4] <= w_slice[3:0];
                        end
                    end
                    r_carry <= w_slice[4];
                    if (r_idx == LAST_IDX) begin
                        r_cout      <= w_slice[4];
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign busy      = r_busy;

endmodule
